// File: rtl/pixel_frequency_detector_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frequency_analysis_defs : shared encodings and window/timeout derivations
// Rev 1.0
// ---------------------------------------------------------------------------
package frequency_analysis_defs;

  typedef enum logic [1:0] {
    CLASS_NONE = 2'd0,
    CLASS_F0   = 2'd1,
    CLASS_F1   = 2'd2
  } freq_class_e;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_ARMED   = 2'd1,
    STATE_MEASURE = 2'd2
  } detector_state_e;

  function automatic logic [31:0] window_lo(input int unsigned clock_hz,
                                            input int unsigned freq_hz,
                                            input int unsigned dev_pct);
    longint unsigned nominal;
    nominal = 64'(clock_hz / freq_hz);
    return 32'((nominal * 64'(32'd100 - dev_pct)) / 64'd100);
  endfunction

  function automatic logic [31:0] window_hi(input int unsigned clock_hz,
                                            input int unsigned freq_hz,
                                            input int unsigned dev_pct);
    longint unsigned nominal;
    nominal = 64'(clock_hz / freq_hz);
    return 32'((nominal * 64'(32'd100 + dev_pct)) / 64'd100);
  endfunction

  function automatic logic [31:0] timeout_cycles(input logic [31:0] hi0,
                                                 input logic [31:0] hi1);
    return (hi0 > hi1) ? hi0 : hi1;
  endfunction

  function automatic logic [31:0] acc_max(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << width) - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_frequency_detector_signal_edge_synchronizer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// signal_edge_synchronizer : 2-flop synchronizer with registered rise pulse
// Rev 1.0
// ---------------------------------------------------------------------------
module signal_edge_synchronizer (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign sync_out   = sync_q;
  assign rise_pulse = rise_q;

endmodule
`default_nettype wire

// File: rtl/pixel_frequency_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_frequency_detector : classifies pixel toggle periods as F0/F1/none
// and accumulates matched period time. Rev 1.0
// ---------------------------------------------------------------------------
module pixel_frequency_detector
  import frequency_analysis_defs::*;
#(
  parameter int unsigned FREQUENCY0           = 5000,
  parameter int unsigned FREQUENCY1           = 10000,
  parameter int unsigned FREQUENCY0_DEVIATION = 20,
  parameter int unsigned FREQUENCY1_DEVIATION = 20,
  parameter int unsigned CLOCK_FREQUENCY      = 100000000,
  parameter int unsigned ACCUMULATOR_WIDTH    = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        sample_data,
  output logic [31:0] f0_value,
  output logic [31:0] f1_value,
  output logic        f0_detected,
  output logic        f1_detected,
  output logic        period_strobe
);

  localparam logic [31:0] LO0     = window_lo(CLOCK_FREQUENCY, FREQUENCY0, FREQUENCY0_DEVIATION);
  localparam logic [31:0] HI0     = window_hi(CLOCK_FREQUENCY, FREQUENCY0, FREQUENCY0_DEVIATION);
  localparam logic [31:0] LO1     = window_lo(CLOCK_FREQUENCY, FREQUENCY1, FREQUENCY1_DEVIATION);
  localparam logic [31:0] HI1     = window_hi(CLOCK_FREQUENCY, FREQUENCY1, FREQUENCY1_DEVIATION);
  localparam logic [31:0] TIMEOUT = timeout_cycles(HI0, HI1);
  localparam logic [31:0] ACC_MAX = acc_max(ACCUMULATOR_WIDTH);

  logic enable_sync, enable_rise_unused;
  logic sample_level_unused, sample_rise;

  signal_edge_synchronizer u_enable_sync (
    .clock      (clock),
    .reset      (reset),
    .async_in   (enable),
    .sync_out   (enable_sync),
    .rise_pulse (enable_rise_unused)
  );

  signal_edge_synchronizer u_sample_sync (
    .clock      (clock),
    .reset      (reset),
    .async_in   (sample_data),
    .sync_out   (sample_level_unused),
    .rise_pulse (sample_rise)
  );

  detector_state_e state_q, state_d;
  logic [31:0]     count_q, count_d;
  logic [31:0]     f0_acc_q, f0_acc_d;
  logic [31:0]     f1_acc_q, f1_acc_d;
  logic            f0_det_q, f0_det_d;
  logic            f1_det_q, f1_det_d;
  logic            strobe_q, strobe_d;
  freq_class_e     period_class;
  logic [32:0]     f0_sum, f1_sum;

  // F0 is tested first so it wins where the two windows overlap.
  always_comb begin
    period_class = CLASS_NONE;
    if (count_q >= LO0 && count_q <= HI0) begin
      period_class = CLASS_F0;
    end else if (count_q >= LO1 && count_q <= HI1) begin
      period_class = CLASS_F1;
    end
  end

  assign f0_sum = {1'b0, f0_acc_q} + {1'b0, count_q};
  assign f1_sum = {1'b0, f1_acc_q} + {1'b0, count_q};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    f0_acc_d = f0_acc_q;
    f1_acc_d = f1_acc_q;
    f0_det_d = f0_det_q;
    f1_det_d = f1_det_q;
    strobe_d = 1'b0;
    if (!enable_sync) begin
      state_d = STATE_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        STATE_IDLE: begin
          state_d = STATE_ARMED;
          count_d = '0;
        end
        STATE_ARMED: begin
          if (sample_rise) begin
            state_d = STATE_MEASURE;
            count_d = 32'd1;
          end
        end
        STATE_MEASURE: begin
          if (sample_rise) begin
            count_d  = 32'd1;
            strobe_d = 1'b1;
            f0_det_d = 1'b0;
            f1_det_d = 1'b0;
            case (period_class)
              CLASS_F0: begin
                f0_acc_d = (f0_sum > {1'b0, ACC_MAX}) ? ACC_MAX : f0_sum[31:0];
                f0_det_d = 1'b1;
              end
              CLASS_F1: begin
                f1_acc_d = (f1_sum > {1'b0, ACC_MAX}) ? ACC_MAX : f1_sum[31:0];
                f1_det_d = 1'b1;
              end
              default: ;
            endcase
          end else begin
            if (count_q != 32'hFFFF_FFFF) begin
              count_d = count_q + 32'd1;
            end
            if (count_q > TIMEOUT) begin
              f0_det_d = 1'b0;
              f1_det_d = 1'b0;
            end
          end
        end
        default: state_d = STATE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= STATE_IDLE;
      count_q  <= '0;
      f0_acc_q <= '0;
      f1_acc_q <= '0;
      f0_det_q <= 1'b0;
      f1_det_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      f0_acc_q <= f0_acc_d;
      f1_acc_q <= f1_acc_d;
      f0_det_q <= f0_det_d;
      f1_det_q <= f1_det_d;
      strobe_q <= strobe_d;
    end
  end

  assign f0_value      = f0_acc_q;
  assign f1_value      = f1_acc_q;
  assign f0_detected   = f0_det_q;
  assign f1_detected   = f1_det_q;
  assign period_strobe = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_frequency_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pixel_frequency_detector : directed bench, clock scaled so LO0=16,
// HI0=24, LO1=8, HI1=12, TIMEOUT=24. Rev 1.0
// ---------------------------------------------------------------------------
module tb_pixel_frequency_detector;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_data;
  logic [31:0] f0_value, f1_value;
  logic        f0_detected, f1_detected, period_strobe;
  logic [31:0] s_f0_value, s_f1_value;
  logic        s_f0_detected, s_f1_detected, s_period_strobe;

  int checks       = 0;
  int errors       = 0;
  int strobe_count = 0;
  int strobe_base  = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (period_strobe) strobe_count <= strobe_count + 1;
  end

  pixel_frequency_detector #(
    .CLOCK_FREQUENCY   (100000),
    .ACCUMULATOR_WIDTH (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .sample_data   (sample_data),
    .f0_value      (f0_value),
    .f1_value      (f1_value),
    .f0_detected   (f0_detected),
    .f1_detected   (f1_detected),
    .period_strobe (period_strobe)
  );

  // Narrow accumulator instance: 4 x 20 = 80 must clamp at 63, not wrap to 16.
  pixel_frequency_detector #(
    .CLOCK_FREQUENCY   (100000),
    .ACCUMULATOR_WIDTH (6)
  ) dut_sat (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .sample_data   (sample_data),
    .f0_value      (s_f0_value),
    .f1_value      (s_f1_value),
    .f0_detected   (s_f0_detected),
    .f1_detected   (s_f1_detected),
    .period_strobe (s_period_strobe)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One rising edge followed by a full period of p cycles.
  task automatic rise(input int p);
    sample_data = 1'b1;
    cycles(p / 2);
    sample_data = 1'b0;
    cycles(p - p / 2);
  endtask

  task automatic rearm();
    enable = 1'b0;
    cycles(5);
    enable = 1'b1;
    cycles(5);
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    sample_data = 1'b0;
    cycles(3);
    check("reset_f0_value", f0_value, 32'd0);
    check("reset_f1_value", f1_value, 32'd0);
    check("reset_f0_det", 32'(f0_detected), 32'd0);
    check("reset_f1_det", 32'(f1_detected), 32'd0);
    check("reset_strobe", 32'(period_strobe), 32'd0);
    check("reset_sat_f0", s_f0_value, 32'd0);
    reset = 1'b0;
    cycles(2);

    // F0: five rises at period 20, first one only arms
    enable = 1'b1;
    cycles(5);
    strobe_base = strobe_count;
    for (int i = 0; i < 5; i++) rise(20);
    check("f0_value", f0_value, 32'd80);
    check("f0_f1_value", f1_value, 32'd0);
    check("f0_det", 32'(f0_detected), 32'd1);
    check("f0_f1_det", 32'(f1_detected), 32'd0);
    check("f0_strobes", strobe_count - strobe_base, 32'd4);
    check("sat_f0_value", s_f0_value, 32'd63);
    check("sat_f1_value", s_f1_value, 32'd0);

    // Timeout: flag survives until the counter passes 24, then drops
    cycles(4);
    check("pre_timeout_f0_det", 32'(f0_detected), 32'd1);
    cycles(11);
    check("timeout_f0_det", 32'(f0_detected), 32'd0);
    check("timeout_f0_value", f0_value, 32'd80);

    // F1 after re-arm; accumulators are not cleared by enable
    rearm();
    strobe_base = strobe_count;
    for (int i = 0; i < 3; i++) rise(10);
    check("f1_value", f1_value, 32'd20);
    check("f1_det", 32'(f1_detected), 32'd1);
    check("f1_f0_det", 32'(f0_detected), 32'd0);
    check("f1_f0_value_kept", f0_value, 32'd80);
    check("f1_strobes", strobe_count - strobe_base, 32'd2);

    // Enable dropped mid-period; a rise while disabled is ignored
    strobe_base = strobe_count;
    enable = 1'b0;
    cycles(3);
    rise(20);
    enable = 1'b1;
    cycles(5);
    for (int i = 0; i < 3; i++) rise(20);
    check("reen_f0_value", f0_value, 32'd120);
    check("reen_f0_det", 32'(f0_detected), 32'd1);
    check("reen_f1_det", 32'(f1_detected), 32'd0);
    check("reen_strobes", strobe_count - strobe_base, 32'd2);
    check("reen_sat_f0", s_f0_value, 32'd63);

    // Out-of-window period 14
    rearm();
    strobe_base = strobe_count;
    for (int i = 0; i < 4; i++) rise(14);
    check("oow_f0_det", 32'(f0_detected), 32'd0);
    check("oow_f1_det", 32'(f1_detected), 32'd0);
    check("oow_f0_value", f0_value, 32'd120);
    check("oow_f1_value", f1_value, 32'd20);
    check("oow_strobes", strobe_count - strobe_base, 32'd3);

    // Window edges: 16 and 24 -> F0, 12 -> F1, 13 and 25 -> none
    strobe_base = strobe_count;
    rise(16);
    rise(24);
    check("lo0_f0_value", f0_value, 32'd136);
    check("lo0_f0_det", 32'(f0_detected), 32'd1);
    rise(12);
    check("hi0_f0_value", f0_value, 32'd160);
    rise(13);
    check("hi1_f1_value", f1_value, 32'd32);
    check("hi1_f1_det", 32'(f1_detected), 32'd1);
    check("hi1_f0_det", 32'(f0_detected), 32'd0);
    rise(25);
    check("gap13_f1_det", 32'(f1_detected), 32'd0);
    check("gap13_f1_value", f1_value, 32'd32);
    rise(8);
    check("p25_f0_value", f0_value, 32'd160);
    check("p25_f1_value", f1_value, 32'd32);
    check("p25_f0_det", 32'(f0_detected), 32'd0);
    rise(20);
    check("lo1_f1_value", f1_value, 32'd40);
    check("lo1_f1_det", 32'(f1_detected), 32'd1);
    check("edge_strobes", strobe_count - strobe_base, 32'd7);
    check("edge_sat_f1", s_f1_value, 32'd40);
    check("edge_sat_f0", s_f0_value, 32'd63);

    // Reset clears everything on the next edge
    reset = 1'b1;
    cycles(1);
    check("rst_f0_value", f0_value, 32'd0);
    check("rst_f1_value", f1_value, 32'd0);
    check("rst_f0_det", 32'(f0_detected), 32'd0);
    check("rst_f1_det", 32'(f1_detected), 32'd0);
    check("rst_strobe", 32'(period_strobe), 32'd0);
    check("rst_sat_f0", s_f0_value, 32'd0);
    reset = 1'b0;
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
